// File: rtl/count_monitor.sv
// count_monitor: checks that a 4-bit counter steps by +1 mod 16, counts wraps,
// flags a programmable match value and queues wrap/error events in a 2-entry FIFO.
module count_monitor #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        count_i,
  input  logic              enable_i,
  input  logic [3:0]        match_val_i,
  input  logic              clr_err_i,
  output logic              match_pulse_o,
  output logic [WRAP_W-1:0] wrap_count_o,
  output logic              step_err_o,
  output logic              overflow_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [4:0]        evt_data_o
);

  typedef enum logic [0:0] {StIdle, StTrack} state_e;

  state_e            state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic              match_q, match_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic [4:0]        mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;

  logic [3:0]        exp_cnt;
  logic              push, pop, full, do_push, drop, set_err;
  logic [4:0]        push_data;

  assign exp_cnt = prev_q + 4'd1;
  assign full    = (cnt_q == 2'd2);
  assign pop     = evt_valid_o & evt_ready_i;
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Tracking FSM, step check, wrap counting and sticky flags.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    wrap_d    = wrap_q;
    push      = 1'b0;
    push_data = 5'd0;
    set_err   = 1'b0;
    match_d   = enable_i && (count_i == match_val_i);
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          prev_d  = count_i;
          state_d = StTrack;
        end
      end
      StTrack: begin
        if (enable_i) begin
          prev_d = count_i;
          if (count_i == exp_cnt) begin
            if (prev_q == 4'd15) begin
              push      = 1'b1;
              push_data = {1'b0, count_i};
              if (wrap_q != {WRAP_W{1'b1}}) begin
                wrap_d = wrap_q + WRAP_W'(1);
              end
            end
          end else begin
            push      = 1'b1;
            push_data = {1'b1, count_i};
            set_err   = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Set wins over a simultaneous clear.
    err_d = set_err | (err_q & ~clr_err_i);
    ovf_d = drop | (ovf_q & ~clr_err_i);
  end

  // FIFO occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      prev_q  <= 4'd0;
      match_q <= 1'b0;
      wrap_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Event FIFO storage and pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= 5'd0;
      mem_q[1] <= 5'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign match_pulse_o = match_q;
  assign wrap_count_o  = wrap_q;
  assign step_err_o    = err_q;
  assign overflow_o    = ovf_q;
  assign evt_valid_o   = (cnt_q != 2'd0);
  assign evt_data_o    = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_count_monitor.sv
// Randomised and directed bench for count_monitor with a queue-based scoreboard.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count = 4'd0;
  logic       enable = 1'b0;
  logic [3:0] match_val = 4'd0;
  logic       clr_err = 1'b0;
  logic       evt_ready = 1'b0;

  logic       match_pulse, step_err, overflow, evt_valid;
  logic [7:0] wrap_count;
  logic [4:0] evt_data;
  logic       match_pulse2, step_err2, overflow2, evt_valid2;
  logic [1:0] wrap_count2;
  logic [4:0] evt_data2;

  count_monitor #(.WRAP_W(8)) dut (
    .clk_i(clk), .rst_i(reset), .count_i(count), .enable_i(enable),
    .match_val_i(match_val), .clr_err_i(clr_err), .match_pulse_o(match_pulse),
    .wrap_count_o(wrap_count), .step_err_o(step_err), .overflow_o(overflow),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_data_o(evt_data)
  );

  count_monitor #(.WRAP_W(2)) dut2 (
    .clk_i(clk), .rst_i(reset), .count_i(count), .enable_i(enable),
    .match_val_i(match_val), .clr_err_i(clr_err), .match_pulse_o(match_pulse2),
    .wrap_count_o(wrap_count2), .step_err_o(step_err2), .overflow_o(overflow2),
    .evt_valid_o(evt_valid2), .evt_ready_i(evt_ready), .evt_data_o(evt_data2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_popped = 0;
  int npulse = 0;

  // Reference model state (plain integers and a queue of expected records).
  bit         m_trk;
  int         m_prev;
  int         m_wraps;
  bit         m_match, m_err, m_ovf;
  int         m_occ;
  logic [4:0] sb_q[$];

  function automatic void chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock of stimulus: update the model, then compare registered outputs.
  task automatic cyc(input bit en, input int c, input bit rdy, input bit clr);
    bit         pop, push, drop, seterr;
    logic [4:0] rec;
    enable = en; count = 4'(c); evt_ready = rdy; clr_err = clr;
    pop = (m_occ > 0) && rdy;
    push = 0; seterr = 0; rec = 5'd0;
    if (en) begin
      if (m_trk) begin
        if ((c % 16) == ((m_prev + 1) % 16)) begin
          if (m_prev == 15) begin
            m_wraps++; push = 1; rec = {1'b0, 4'(c)};
          end
        end else begin
          push = 1; rec = {1'b1, 4'(c)}; seterr = 1;
        end
      end
      m_trk = 1;
      m_prev = c % 16;
      m_match = ((c % 16) == int'(match_val));
    end else begin
      m_trk = 0;
      m_match = 0;
    end
    drop = push && (m_occ == 2) && !pop;
    if (push && !drop) begin
      sb_q.push_back(rec);
      m_occ++;
    end
    if (pop) m_occ--;
    m_err = seterr || (m_err && !clr);
    m_ovf = drop || (m_ovf && !clr);
    @(posedge clk);
    #1;
    if (match_pulse) npulse++;
    chk("match_pulse", match_pulse, m_match);
    chk("wrap_count", wrap_count, sat(m_wraps, 255));
    chk("wrap_count_w2", wrap_count2, sat(m_wraps, 3));
    chk("step_err", step_err, m_err);
    chk("overflow", overflow, m_ovf);
    chk("evt_valid", evt_valid, m_occ > 0);
    chk("evt_valid_w2", evt_valid2, m_occ > 0);
  endtask

  task automatic apply_reset();
    enable = 0; evt_ready = 0; clr_err = 0;
    reset = 1;
    #1;
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_data", evt_data, 0);
    chk("rst_wrap_count", wrap_count, 0);
    chk("rst_step_err", step_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_match_pulse", match_pulse, 0);
    m_trk = 0; m_prev = 0; m_wraps = 0; m_match = 0; m_err = 0; m_ovf = 0; m_occ = 0;
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  // Scoreboard monitor: compare each record as it is handed over.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL evt_unexpected: got %0h expected none", evt_data);
      end else begin
        logic [4:0] e;
        e = sb_q.pop_front();
        chk("evt_data", evt_data, e);
        chk("evt_data_w2", evt_data2, e);
      end
      n_popped++;
    end
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ctr;
    int base;
    int rc;
    #1;
    apply_reset();

    // Free-running counter from reset, 40 samples: two wraps to 0.
    ctr = 0; base = n_popped;
    for (int i = 0; i < 40; i++) begin cyc(1, ctr, 1, 0); ctr++; end
    chk("t1_wrap_count", wrap_count, 2);
    chk("t1_step_err", step_err, 0);
    chk("t1_pops", n_popped - base, 2);

    // Match on 5 over 32 free-running samples.
    match_val = 4'd5; npulse = 0;
    for (int i = 0; i < 32; i++) begin cyc(1, ctr, 1, 0); ctr++; end
    chk("t2_pulses", npulse, 2);

    // Directed step error: 3,4,9,10 after a resync.
    cyc(0, 0, 1, 0);
    cyc(1, 3, 1, 0);
    cyc(1, 4, 1, 0);
    chk("t3_no_err", step_err, 0);
    cyc(1, 9, 1, 0);
    chk("t3_err", step_err, 1);
    cyc(1, 10, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);

    // Overflow with consumer stalled.
    cyc(1, 0, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 4, 0, 0);
    cyc(1, 6, 0, 0);
    chk("t4_valid", evt_valid, 1);
    chk("t4_overflow", overflow, 1);
    chk("t4_head", evt_data, 5'h12);
    base = n_popped;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("t4_pops", n_popped - base, 2);
    cyc(0, 0, 1, 1);
    chk("t4_clr_err", step_err, 0);
    chk("t4_clr_ovf", overflow, 0);

    // Enable gap resyncs without error.
    ctr = 7;
    for (int i = 0; i < 5; i++) begin cyc(1, ctr, 1, 0); ctr++; end
    for (int i = 0; i < 3; i++) begin cyc(0, ctr, 1, 0); ctr++; end
    for (int i = 0; i < 5; i++) begin cyc(1, ctr, 1, 0); ctr++; end
    chk("t5_no_err", step_err, 0);
    cyc(1, ctr + 5, 0, 0);
    chk("t5_queued", evt_valid, 1);
    apply_reset();

    // Wrap saturation: narrow instance saturates at 3, events keep coming.
    ctr = 0; base = n_popped;
    for (int i = 0; i < 82; i++) begin cyc(1, ctr, 1, 0); ctr++; end
    chk("t6_wrap_w2", wrap_count2, 3);
    chk("t6_pops", n_popped - base, 5);
    for (int i = 0; i < 251 * 16; i++) begin cyc(1, ctr, 1, 0); ctr++; end
    chk("t6_wrap_sat", wrap_count, 255);
    base = n_popped;
    for (int i = 0; i < 16; i++) begin cyc(1, ctr, 1, 0); ctr++; end
    chk("t6_wrap_still_sat", wrap_count, 255);
    chk("t6_sat_pop", n_popped - base, 1);

    // Randomised phase.
    rc = 0;
    for (int i = 0; i < 3000; i++) begin
      int c;
      if ($urandom_range(0, 99) == 0) match_val = 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : rc;
      rc = (c + 1) % 16;
      cyc($urandom_range(0, 7) != 0, c, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk("final_sb_empty", sb_q.size(), 0);
    chk("final_valid", evt_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Downstream checker for the 4-bit free-running counter. It samples the counter's `count` output every enabled cycle and checks that each sample is the previous one plus 1, mod 16. It counts 15→0 wrap-arounds, pulses on a programmable match value, and queues wrap and error events in a 2-entry buffer with a valid/ready handshake for a consumer such as a logger or interrupt controller.

## Interface
- `WRAP_W`, 8: width of the saturating wrap counter.
- `clk`  in  1  rising-edge clock, shared with the counter.
- `reset`  in  1  asynchronous, active-high reset.
- `count`  in  4  counter value under observation.
- `enable`  in  1  sample `count` this cycle.
- `match_val`  in  4  value that triggers `match_pulse`.
- `clr_err`  in  1  synchronous clear of `step_err` and `overflow`.
- `match_pulse`  out  1  one-cycle pulse when a sampled count equals `match_val`.
- `wrap_count`  out  WRAP_W  number of 15→0 transitions seen; saturates at all-ones.
- `step_err`  out  1  sticky; a non-incrementing step was seen.
- `overflow`  out  1  sticky; an event was dropped because the buffer was full.
- `evt_valid`  out  1  event record available.
- `evt_ready`  in  1  consumer accepts the record.
- `evt_data`  out  5  record: {type, count}; type 0 = wrap, type 1 = step error.

## Operation
- **States.** IDLE and TRACK. A register `prev[3:0]` holds the last sample.
- **IDLE.** On `enable`=1: load `prev`←`count` and go to TRACK. No checks, no events, no wrap increment. If `count`==`match_val`, still pulse `match_pulse`.
- **TRACK, `enable`=1.** Let exp = `prev`+1, mod 16.
  - If `count`==exp and `prev`==15: increment `wrap_count` (saturating) and push a wrap event {0, `count`}.
  - If `count`≠exp: set `step_err` and push an error event {1, `count`}.
  - In both cases, `prev`←`count`.
- **TRACK, `enable`=0.** Return to IDLE. The next enabled sample resynchronises and is not checked.
- **Match.** `match_pulse`=1 for exactly the cycle after any enabled sample with `count`==`match_val`, in either state.
- **Event buffer.** 2-entry FIFO, first in, first out.
  - A pop occurs when `evt_valid`&&`evt_ready`.
  - A push when full with no pop that cycle: event dropped, `overflow` set.
  - Push and pop in the same cycle while full: both take effect, nothing is dropped.
  - Push while empty: the record appears on the next cycle.
  - `evt_data` is held stable while `evt_valid`=1 and `evt_ready`=0.
- **Saturated wrap counter.** Wrap events are still pushed after `wrap_count` saturates.
- **Clearing.** `clr_err` clears `step_err` and `overflow` on the next edge. A set and a clear in the same cycle resolve to set. `clr_err` does not affect the FIFO or `wrap_count`.
- **Widths.** `count`, `prev` and `match_val` compare as unsigned 4-bit values. The only arithmetic is the increment, which wraps mod 16.

## Timing
- **Reset values.** Asserting `reset` immediately forces:
  - state=IDLE, `prev`=0, FIFO empty
  - `match_pulse`=0, `wrap_count`=0, `step_err`=0, `overflow`=0
  - `evt_valid`=0, `evt_data`=0
- **Reset mid-operation.** All of the above is discarded, including queued events. The first enabled cycle after release is a resync sample.
- **Latency.** For a sample presented before edge N:
  - `match_pulse`, `wrap_count` and `step_err` update at edge N.
  - `evt_valid` rises at edge N if the FIFO was empty.
- **Throughput.** With `evt_ready` held high, one event per cycle is drained.
- **Registered outputs.** All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
1. Reset the counter and this block together, then hold `enable`=1 for 40 cycles with `evt_ready`=1.
   - `wrap_count`=2, `step_err`=0.
   - Two wrap events, each {0, 0}.
2. `match_val`=5 with a free-running counter.
   - `match_pulse` fires every 16 cycles, one cycle after `count`=5 is sampled.
3. Drive `count` sequence 3, 4, 9, 10 (no counter instance).
   - `step_err` rises after 9 is sampled.
   - Event {1, 9} is queued; 10 raises no error.
4. Hold `evt_ready`=0 and force 3 step errors (counts 0, 2, 4, 6).
   - `evt_valid`=1 and `overflow`=1.
   - Records {1, 2} then {1, 4} are drained in that order.
   - Then assert `clr_err`: `overflow` and `step_err` clear.
5. `enable` low for 3 cycles mid-count, then high again.
   - No error (resync).
   - Assert `reset` mid-stream with a queued event: `evt_valid` drops immediately and `wrap_count`=0.
6. Force `WRAP_W`=2 and run 5 wraps.
   - `wrap_count` saturates at 3.
   - A 5th wrap event is still delivered.
